// File: rtl/alu_operand_sequencer.sv
// ALU front end: debounced keys drive an operand/opcode entry FSM.
// Emits registered A/B/S plus phase status and a command-valid flag.
module alu_key_debounce #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Accept the synchronized level only after it has held for CYCLES clocks.
  always_comb begin
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = deb_q & ~deb_d;
  end

  // Synchronizer, counter, debounced level and press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module alu_operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0]  MAX_OP          = 4'd12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] SW,
  input  logic       key_enter_n,
  input  logic       key_back_n,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [3:0] S,
  output logic       op_valid,
  output logic [1:0] phase,
  output logic       op_err
);
  localparam logic [1:0] LOAD_A  = 2'b00;
  localparam logic [1:0] LOAD_B  = 2'b01;
  localparam logic [1:0] LOAD_OP = 2'b10;
  localparam logic [1:0] RUN     = 2'b11;

  logic enter_ev, back_ev;

  alu_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_enter_n),
    .press (enter_ev)
  );

  alu_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_back_n),
    .press (back_ev)
  );

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] s_q, s_d;
  logic [1:0] phase_q, phase_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  // Entry FSM: back outranks enter when both fire together.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    phase_d = phase_q;
    err_d   = 1'b0;
    if (back_ev) begin
      unique case (phase_q)
        LOAD_A:  phase_d = LOAD_A;
        LOAD_B:  phase_d = LOAD_A;
        LOAD_OP: phase_d = LOAD_B;
        RUN:     phase_d = LOAD_OP;
        default: phase_d = LOAD_A;
      endcase
    end else if (enter_ev) begin
      unique case (phase_q)
        LOAD_A: begin
          a_d     = SW[7:0];
          phase_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = SW[7:0];
          phase_d = LOAD_OP;
        end
        LOAD_OP: begin
          if (SW[3:0] <= MAX_OP) begin
            s_d     = SW[3:0];
            phase_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
        RUN:     phase_d = LOAD_A;
        default: phase_d = LOAD_A;
      endcase
    end
    valid_d = (phase_d == RUN);
  end

  // Operand, opcode and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      phase_q <= LOAD_A;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign S        = s_q;
  assign phase    = phase_q;
  assign op_valid = valid_q;
  assign op_err   = err_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a short debounce.
// Walks entry, rejection, bounce, collision and reset scenarios.
module tb_alu_operand_sequencer;
  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [9:0] SW;
  logic       key_enter_n;
  logic       key_back_n;
  logic [7:0] A, B;
  logic [3:0] S;
  logic       op_valid;
  logic [1:0] phase;
  logic       op_err;

  int total  = 0;
  int passed = 0;
  int err_cnt = 0;
  int chg_cnt = 0;
  logic [1:0] prev_phase = 2'b00;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(D), .MAX_OP(4'd12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SW          (SW),
    .key_enter_n (key_enter_n),
    .key_back_n  (key_back_n),
    .A           (A),
    .B           (B),
    .S           (S),
    .op_valid    (op_valid),
    .phase       (phase),
    .op_err      (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count op_err pulse cycles and phase changes between steps.
  always @(negedge clk) begin
    if (op_err) err_cnt++;
    if (phase != prev_phase) chg_cnt++;
    prev_phase = phase;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press(input logic e, input logic b);
    key_enter_n = ~e;
    key_back_n  = ~b;
    cyc(D + 8);
    key_enter_n = 1'b1;
    key_back_n  = 1'b1;
    cyc(D + 8);
  endtask

  initial begin
    rst_n       = 1'b0;
    SW          = '0;
    key_enter_n = 1'b1;
    key_back_n  = 1'b1;
    cyc(3);
    chk("rst_A", A, 8'h00);
    chk("rst_B", B, 8'h00);
    chk("rst_S", {4'h0, S}, 8'h00);
    chk("rst_valid", {7'h0, op_valid}, 8'h00);
    chk("rst_phase", {6'h0, phase}, 8'h00);
    chk("rst_err", {7'h0, op_err}, 8'h00);
    rst_n = 1'b1;
    cyc(3);

    // full entry
    SW = 10'h02A; press(1, 0);
    chk("t1_phaseB", {6'h0, phase}, 8'h01);
    chk("t1_A", A, 8'h2A);
    SW = 10'h015; press(1, 0);
    chk("t1_phaseOP", {6'h0, phase}, 8'h02);
    chk("t1_B", B, 8'h15);
    SW = 10'h003; press(1, 0);
    chk("t1_phaseRUN", {6'h0, phase}, 8'h03);
    chk("t1_S", {4'h0, S}, 8'h03);
    chk("t1_valid", {7'h0, op_valid}, 8'h01);
    chk("t1_A2", A, 8'h2A);
    chk("t1_B2", B, 8'h15);

    // back from RUN, re-enter
    press(0, 1);
    chk("t5_phase", {6'h0, phase}, 8'h02);
    chk("t5_valid", {7'h0, op_valid}, 8'h00);
    press(1, 0);
    chk("t5_phaseRUN", {6'h0, phase}, 8'h03);
    chk("t5_S", {4'h0, S}, 8'h03);

    // illegal opcode rejected, then boundary legal code
    press(0, 1);
    err_cnt = 0;
    SW = 10'h00D; press(1, 0);
    chk("t2_errcnt", 8'(err_cnt), 8'd1);
    chk("t2_phase", {6'h0, phase}, 8'h02);
    chk("t2_S", {4'h0, S}, 8'h03);
    chk("t2_valid", {7'h0, op_valid}, 8'h00);
    chk("t2_err_low", {7'h0, op_err}, 8'h00);
    SW = 10'h30C; press(1, 0);
    chk("t2_max_phase", {6'h0, phase}, 8'h03);
    chk("t2_max_S", {4'h0, S}, 8'h0C);
    press(1, 0);
    chk("t2_wrap_phase", {6'h0, phase}, 8'h00);
    chk("t2_wrap_A", A, 8'h2A);
    chk("t2_wrap_S", {4'h0, S}, 8'h0C);

    // bouncy enter
    SW = 10'h077;
    chg_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      key_enter_n = 1'b0; cyc(2);
      key_enter_n = 1'b1; cyc(2);
    end
    chk("t3_nobounce", 8'(chg_cnt), 8'd0);
    key_enter_n = 1'b0; cyc(D + 20);
    key_enter_n = 1'b1; cyc(D + 20);
    chk("t3_events", 8'(chg_cnt), 8'd1);
    chk("t3_phase", {6'h0, phase}, 8'h01);
    chk("t3_A", A, 8'h77);

    // simultaneous enter and back from LOAD_B
    SW = 10'h099;
    chg_cnt = 0;
    press(1, 1);
    chk("t4_phase", {6'h0, phase}, 8'h00);
    chk("t4_B", B, 8'h15);
    chk("t4_events", 8'(chg_cnt), 8'd1);

    // reset mid-debounce in LOAD_OP
    SW = 10'h011; press(1, 0);
    SW = 10'h022; press(1, 0);
    chk("t6_pre_phase", {6'h0, phase}, 8'h02);
    key_enter_n = 1'b0;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_phase", {6'h0, phase}, 8'h00);
    chk("t6_rst_A", A, 8'h00);
    chk("t6_rst_B", B, 8'h00);
    chk("t6_rst_S", {4'h0, S}, 8'h00);
    key_enter_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    chg_cnt = 0;
    cyc(D + 20);
    chk("t6_noevent", 8'(chg_cnt), 8'd0);
    chk("t6_phase", {6'h0, phase}, 8'h00);
    chk("t6_A", A, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
